// File: rtl/pwm_pkg.sv
// Shared types for the dead-time inserter: per-phase state encoding and default widths.
package pwm_pkg;

    localparam int DT_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        OFF,
        LOW_ON,
        DT_TO_HIGH,
        HIGH_ON,
        DT_TO_LOW
    } dt_state_t;

endpackage

// File: rtl/deadtime_phase.sv
// One half-bridge: turns a single PWM command into complementary high/low drives with a
// programmable both-off band between every handover.
module deadtime_phase
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CMD,
    input  logic [DT_WIDTH-1:0] DEAD_TIME,
    output logic                HI_OUT,
    output logic                LO_OUT,
    output logic                DT_ACTIVE
);

    dt_state_t           state, state_nxt;
    logic [DT_WIDTH-1:0] cnt, cnt_nxt;
    logic [DT_WIDTH-1:0] load_val;

    // Band length is max(DEAD_TIME,1); the counter holds remaining edges minus one.
    assign load_val = (DEAD_TIME == '0) ? '0 : DEAD_TIME - DT_WIDTH'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            OFF: begin
                state_nxt = CMD ? DT_TO_HIGH : DT_TO_LOW;
                cnt_nxt   = load_val;
            end
            LOW_ON: begin
                if (CMD) begin
                    state_nxt = DT_TO_HIGH;
                    cnt_nxt   = load_val;
                end
            end
            DT_TO_HIGH: begin
                // Command withdrawn before the high side ever came on: return without a band.
                if (!CMD)
                    state_nxt = LOW_ON;
                else if (cnt == '0)
                    state_nxt = HIGH_ON;
                else
                    cnt_nxt = cnt - DT_WIDTH'(1);
            end
            HIGH_ON: begin
                if (!CMD) begin
                    state_nxt = DT_TO_LOW;
                    cnt_nxt   = load_val;
                end
            end
            DT_TO_LOW: begin
                if (CMD)
                    state_nxt = HIGH_ON;
                else if (cnt == '0)
                    state_nxt = LOW_ON;
                else
                    cnt_nxt = cnt - DT_WIDTH'(1);
            end
            default: begin
                state_nxt = OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Drives are flopped from the next-state decode so they change on the same edge as the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= OFF;
            cnt       <= '0;
            HI_OUT    <= 1'b0;
            LO_OUT    <= 1'b0;
            DT_ACTIVE <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            HI_OUT    <= (state_nxt == HIGH_ON);
            LO_OUT    <= (state_nxt == LOW_ON);
            DT_ACTIVE <= (state_nxt == DT_TO_HIGH) || (state_nxt == DT_TO_LOW);
        end
    end

endmodule

// File: rtl/deadtime_insert.sv
// Three-phase dead-time inserter: U/V/W high-side and X/Y/Z low-side gate drives,
// one independent phase engine per leg sharing a common DEAD_TIME.
module deadtime_insert
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                PWM_U,
    input  logic                PWM_V,
    input  logic                PWM_W,
    input  logic [DT_WIDTH-1:0] DEAD_TIME,
    output logic                U_OUT,
    output logic                V_OUT,
    output logic                W_OUT,
    output logic                X_OUT,
    output logic                Y_OUT,
    output logic                Z_OUT,
    output logic [2:0]          DT_ACTIVE
);

    deadtime_phase #(.DT_WIDTH(DT_WIDTH)) u_phase_u (
        .CLK       (CLK),
        .RST       (RST),
        .CMD       (PWM_U),
        .DEAD_TIME (DEAD_TIME),
        .HI_OUT    (U_OUT),
        .LO_OUT    (X_OUT),
        .DT_ACTIVE (DT_ACTIVE[0])
    );

    deadtime_phase #(.DT_WIDTH(DT_WIDTH)) u_phase_v (
        .CLK       (CLK),
        .RST       (RST),
        .CMD       (PWM_V),
        .DEAD_TIME (DEAD_TIME),
        .HI_OUT    (V_OUT),
        .LO_OUT    (Y_OUT),
        .DT_ACTIVE (DT_ACTIVE[1])
    );

    deadtime_phase #(.DT_WIDTH(DT_WIDTH)) u_phase_w (
        .CLK       (CLK),
        .RST       (RST),
        .CMD       (PWM_W),
        .DEAD_TIME (DEAD_TIME),
        .HI_OUT    (W_OUT),
        .LO_OUT    (Z_OUT),
        .DT_ACTIVE (DT_ACTIVE[2])
    );

endmodule

// File: tb/tb_deadtime_insert.sv
// Directed plus random bench for deadtime_insert against a timestamp-based reference model.
module tb_deadtime_insert;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PWM_U = 1'b0, PWM_V = 1'b0, PWM_W = 1'b0;
    logic [7:0] DEAD_TIME = 8'd4;
    logic       U_OUT, V_OUT, W_OUT, X_OUT, Y_OUT, Z_OUT;
    logic [2:0] DT_ACTIVE;

    int total = 0;
    int bad   = 0;
    int n     = 0;     // edges since last reset release

    // Reference model: which side owns the leg, and while handing over, the target
    // side and the absolute edge number at which it may come on.
    int side [3];
    int tgt  [3];
    int ready[3];
    bit inband [3];
    bit started[3];

    deadtime_insert #(.DT_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST),
        .PWM_U(PWM_U), .PWM_V(PWM_V), .PWM_W(PWM_W),
        .DEAD_TIME(DEAD_TIME),
        .U_OUT(U_OUT), .V_OUT(V_OUT), .W_OUT(W_OUT),
        .X_OUT(X_OUT), .Y_OUT(Y_OUT), .Z_OUT(Z_OUT),
        .DT_ACTIVE(DT_ACTIVE)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 3; i++) begin
            side[i] = -1; tgt[i] = -1; ready[i] = 0;
            inband[i] = 1'b0; started[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [2:0] cmd, input int dt);
        int d;
        d = (dt == 0) ? 1 : dt;
        n++;
        for (int i = 0; i < 3; i++) begin
            if (!started[i]) begin
                started[i] = 1'b1; inband[i] = 1'b1; tgt[i] = int'(cmd[i]); ready[i] = n + d;
            end else if (inband[i]) begin
                if (int'(cmd[i]) != tgt[i]) begin
                    side[i] = int'(cmd[i]); inband[i] = 1'b0;
                end else if (n >= ready[i]) begin
                    side[i] = tgt[i]; inband[i] = 1'b0;
                end
            end else if (int'(cmd[i]) != side[i]) begin
                inband[i] = 1'b1; tgt[i] = int'(cmd[i]); ready[i] = n + d;
            end
        end
    endtask

    function automatic logic [2:0] exp_phase(input int i);
        return {!inband[i] && side[i] == 1, !inband[i] && side[i] == 0, inband[i]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_u"}, {29'd0, U_OUT, X_OUT, DT_ACTIVE[0]}, {29'd0, exp_phase(0)});
        chk({tag, "_v"}, {29'd0, V_OUT, Y_OUT, DT_ACTIVE[1]}, {29'd0, exp_phase(1)});
        chk({tag, "_w"}, {29'd0, W_OUT, Z_OUT, DT_ACTIVE[2]}, {29'd0, exp_phase(2)});
        chk({tag, "_ovl"}, {29'd0, U_OUT & X_OUT, V_OUT & Y_OUT, W_OUT & Z_OUT}, 32'd0);
    endtask

    task automatic step(input logic [2:0] cmd, input int dt, input string tag);
        {PWM_W, PWM_V, PWM_U} = cmd;
        DEAD_TIME = dt[7:0];
        @(posedge CLK);
        model_edge(cmd, dt);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [2:0] cmd;
        int dt, cnt_dt;

        model_reset();
        #12;
        check_all("reset");
        RST = 1'b0;

        // Rising U command with a 4-cycle band
        for (int e = 1; e <= 30; e++) begin
            step({2'b00, e >= 20}, 4, "t1");
            if (e == 20) chk("t1_x_fall", {31'd0, X_OUT}, 32'd0);
            if (e == 20) chk("t1_dt_on", {31'd0, DT_ACTIVE[0]}, 32'd1);
            if (e == 23) chk("t1_u_still_off", {31'd0, U_OUT}, 32'd0);
            if (e == 24) chk("t1_u_rise", {31'd0, U_OUT}, 32'd1);
        end
        // Falling U command
        for (int e = 31; e <= 50; e++) begin
            step({2'b00, e < 40}, 4, "t2");
            if (e == 40) chk("t2_u_fall", {31'd0, U_OUT}, 32'd0);
            if (e == 43) chk("t2_x_still_off", {31'd0, X_OUT}, 32'd0);
            if (e == 44) chk("t2_x_rise", {31'd0, X_OUT}, 32'd1);
        end
        // Two-cycle pulse is swallowed
        for (int e = 51; e <= 70; e++) begin
            step({2'b00, e == 60 || e == 61}, 4, "t3");
            if (e == 61) chk("t3_x_off", {30'd0, X_OUT, U_OUT}, 32'd0);
            if (e == 62) chk("t3_x_back", {31'd0, X_OUT}, 32'd1);
            if (e == 63) chk("t3_u_never", {31'd0, U_OUT}, 32'd0);
        end

        // DEAD_TIME=0 acts as 1: one-cycle band on every V toggle
        for (int e = 0; e < 24; e++) begin
            step({1'b0, (e / 3) % 2 == 1, 1'b0}, 0, "t4a");
            if (e == 3) chk("t4a_band1", {30'd0, V_OUT, Y_OUT}, 32'd0);
            if (e == 4) chk("t4a_v_on", {31'd0, V_OUT}, 32'd1);
        end
        for (int e = 0; e < 5; e++) step(3'b000, 0, "t4b");
        cnt_dt = 0;
        for (int e = 0; e < 300; e++) begin
            step(3'b010, 255, "t4c");
            if (DT_ACTIVE[1]) cnt_dt++;
        end
        chk("t4c_band255", cnt_dt, 32'd255);
        chk("t4c_v_on", {31'd0, V_OUT}, 32'd1);

        // Reset in the middle of a W band, CNT=2
        for (int e = 0; e < 10; e++) step(3'b000, 4, "t5a");
        step(3'b100, 4, "t5b");
        step(3'b100, 4, "t5b");
        #2;
        RST = 1'b1;
        #1;
        chk("t5_rst_drives", {25'd0, U_OUT, V_OUT, W_OUT, X_OUT, Y_OUT, Z_OUT, DT_ACTIVE}, 32'd0);
        model_reset();
        @(posedge CLK);
        #3;
        RST = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step(3'b100, 4, "t5c");
            if (e == 4) chk("t5_w_wait", {31'd0, W_OUT}, 32'd0);
            if (e == 5) chk("t5_w_rise", {31'd0, W_OUT}, 32'd1);
        end

        // Random commands and dead times
        cmd = 3'b000;
        dt  = 3;
        for (int e = 0; e < 3000; e++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 5) == 0) cmd[i] = ~cmd[i];
            if ($urandom_range(0, 49) == 0) dt = $urandom_range(0, 6);
            step(cmd, dt, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
